// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: op codes, FSM encoding and bus width defaults shared by
// the load/store sequencer, its bus interface and the data RAM instance.
package data_mem_ctrl_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 1;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_SWAP  = 2'b10,
        OP_INC   = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_RSP  = 3'd4
    } state_t;

    // State entered from IDLE when a request with this op is accepted.
    function automatic state_t first_state(op_t op);
        state_t s;
        case (op)
            OP_STORE: s = S_WR;
`ifdef DATA_MEM_CTRL_RMW_EN
            OP_INC:   s = S_RD;
`else
            OP_INC:   s = S_RSP;
`endif
            default:  s = S_RD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response channel between the datapath (master)
// and the load/store sequencer (slave).
interface data_mem_ctrl_if
    import data_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    op_t               req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid,
        output req_op,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );

endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: one-at-a-time load/store sequencer for the registered-read
// data RAM. Define DATA_MEM_CTRL_RMW_EN to enable the INC read-modify-write op.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    data_mem_ctrl_if.slave    bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_q;
    state_t            state_d;
    op_t               op_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] old_q;
    logic              accept;

`ifdef DATA_MEM_CTRL_RMW_EN
    logic [DATA_W-1:0] inc_val;
    assign inc_val = mem_rdata + DATA_W'(1);
`endif

    assign accept        = bus.req_valid && (state_q == S_IDLE);
    assign bus.req_ready = (state_q == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_d = first_state(bus.req_op);
                end
            end
            S_RD:    state_d = S_CAP;
            S_CAP:   state_d = (op_q == OP_LOAD) ? S_RSP : S_WR;
            S_WR:    state_d = S_RSP;
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes follow the state being entered, so each lasts one state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q          <= OP_LOAD;
            wdata_q       <= '0;
            old_q         <= '0;
            mem_addr      <= '0;
            mem_data      <= '0;
            mem_we        <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            mem_we        <= (state_d == S_WR);
            bus.rsp_valid <= (state_d == S_RSP);
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= bus.req_op;
                        wdata_q  <= bus.req_wdata;
                        mem_addr <= bus.req_addr;
                        if (bus.req_op == OP_STORE) begin
                            mem_data <= bus.req_wdata;
                        end
`ifndef DATA_MEM_CTRL_RMW_EN
                        if (bus.req_op == OP_INC) begin
                            bus.rsp_err <= 1'b1;
                        end
`endif
                    end
                end
                S_CAP: begin
                    old_q <= mem_rdata;
                    unique case (op_q)
                        OP_LOAD: begin
                            bus.rsp_data <= mem_rdata;
                            bus.rsp_err  <= 1'b0;
                        end
`ifdef DATA_MEM_CTRL_RMW_EN
                        OP_INC:  mem_data <= inc_val;
`endif
                        default: mem_data <= wdata_q;
                    endcase
                end
                S_WR: begin
                    bus.rsp_err  <= 1'b0;
                    bus.rsp_data <= (op_q == OP_SWAP) ? old_q : mem_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Load/store sequencer sitting directly upstream of the processor's 8-bit data RAM.
- Accepts one memory request at a time from the datapath over a valid/ready handshake.
- Drives the RAM's data/address/write-enable inputs and hides the RAM's one-cycle registered-read latency.
- Returns a single-cycle response pulse carrying read data or an acknowledge.

Parameters:
- DATA_W, 8, width of data words and RAM data bus.
- ADDR_W, 1, width of RAM word address (2 words).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_op  input  2  00 LOAD, 01 STORE, 10 SWAP, 11 INC.
- req_addr  input  ADDR_W  target word address.
- req_wdata  input  DATA_W  store/swap data.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_data  output  DATA_W  response data.
- rsp_err  output  1  qualifies rsp_valid; 1 = unsupported op.
- mem_addr  output  ADDR_W  RAM address.
- mem_data  output  DATA_W  RAM write data.
- mem_we  output  1  RAM write enable.
- mem_rdata  input  DATA_W  RAM read port; reflects the address registered at the previous edge.

Behaviour:
- One clock; reset is asynchronous and active-low.
- All outputs are registered except req_ready (decoded from state).
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_err 0, rsp_data 0, mem_addr 0, mem_data 0, mem_we 0.
- Handshake: a request is accepted on an edge where req_valid && req_ready. req_op, req_addr and req_wdata are captured into internal registers at that edge.
- req_ready is 1 only in IDLE, so there is no back-to-back acceptance.
- The response channel has no backpressure.
- States: IDLE, RD, CAP, WR, RSP.
- IDLE, on accept:
  - mem_addr <= req_addr.
  - LOAD/SWAP/INC -> RD.
  - STORE -> WR, with mem_we <= 1 and mem_data <= req_wdata.
- RD: RAM registers the address at this edge -> CAP.
- CAP: mem_rdata is valid and is latched into an old-value register.
  - LOAD -> RSP, with rsp_data = old.
  - SWAP -> WR, with mem_data = captured wdata and mem_we = 1.
  - INC -> WR, with mem_data = (old + 1) mod 2^DATA_W and mem_we = 1.
- WR: mem_we is high for exactly one cycle; at the edge ending WR, mem_we <= 0 -> RSP.
- RSP: rsp_valid = 1 for one cycle -> IDLE.
  - LOAD: rsp_data = read value.
  - STORE: rsp_data = wdata.
  - SWAP: rsp_data = old value.
  - INC: rsp_data = incremented value.
- Latency from accept edge to rsp_valid high:
  - LOAD: 3 cycles.
  - STORE: 2 cycles.
  - SWAP/INC: 4 cycles.
- req_ready returns to 1 in the cycle after rsp_valid.
- rsp_data holds its value between responses.
- Increment arithmetic is DATA_W bits; 0xFF + 1 wraps to 0x00 and no carry is reported.
- Reset mid-operation: state -> IDLE and mem_we -> 0 immediately. Any pending response is dropped; no spurious write occurs after rst_n deasserts.
- Request inputs are ignored while req_ready = 0.

Optional Feature:
- Macro: DATA_MEM_CTRL_RMW_EN.
- Defined: op 11 (INC) performs the read-modify-write described above.
- Undefined: op 11 is unsupported and enters no memory states. The accept edge goes to RSP with rsp_err = 1 and rsp_data unchanged, so rsp_valid rises 1 cycle after accept. mem_we never asserts, and the incrementer logic is absent.

Decomposition:
- Shared package holds:
  - op code constants OP_LOAD, OP_STORE, OP_SWAP, OP_INC.
  - state encoding constants.
  - DATA_W/ADDR_W defaults, shared with the RAM instance.
- No sub-module: the FSM plus datapath registers form one block.
- Integration: top level connects mem_* to the RAM's data, addr_d, we_d and out_dram.

Test Plan:
- Reset asserted mid-SWAP in WR -> mem_we falls to 0 asynchronously, req_ready = 1, and the RAM word is unchanged after release.
- STORE addr 1, data 0xA5, then LOAD addr 1:
  - STORE: rsp_valid 2 cycles after accept, with rsp_data 0xA5.
  - LOAD: rsp_valid 3 cycles after accept, with rsp_data 0xA5.
- Word 0 = 0x3C, SWAP addr 0 with 0x77 -> rsp_data 0x3C at 4 cycles; a following LOAD addr 0 returns 0x77.
- With DATA_MEM_CTRL_RMW_EN:
  - Word 1 = 0xFF, INC addr 1 -> rsp_data 0x00, word reads back 0x00.
  - Word = 0x41 -> response 0x42.
- Without DATA_MEM_CTRL_RMW_EN: op 11 -> rsp_valid 1 cycle after accept with rsp_err 1, mem_we never high.
- req_valid held high with alternating ops -> exactly one accept per req_ready window.
  - No accept while busy.
  - rsp_valid is exactly one cycle wide.
  - mem_we is exactly one cycle per STORE/SWAP/INC.
